// File: rtl/data_sram_responder.sv
// data_sram_responder
//   Memory-side responder for the CPU data SRAM port. Each access is decoded
//   either to a word RAM (byte-lane writes) or to a small MMIO register file
//   (LED, switch, seven-segment number, free-running timer). Read data is
//   registered and appears the cycle after the request, then holds until the
//   next read.
//
//   Optional build macro: TIMER_CMP_EN adds the timer compare register at
//   offset 16'hE004 and the sticky timer_irq output. Without it timer_irq is
//   tied low and 16'hE004 reads as zero.
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   sram_en     access request this cycle
//   sram_we     byte write enables (all zero with sram_en = read)
//   sram_addr   byte address, bits [1:0] ignored
//   sram_wdata  write data, lane i = sram_wdata[8i+7:8i]
//   sram_rdata  read data, valid from the cycle after the read request
//   switch_in   asynchronous board switches
//   led_out     LED register
//   num_out     seven-segment number register
//   timer_irq   timer compare interrupt
module data_sram_responder #(
    parameter int          RAM_AW  = 12,
    parameter logic [15:0] MMIO_HI = 16'hBFAF,
    parameter int          SW_W    = 8
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            sram_en,
    input  logic [3:0]      sram_we,
    input  logic [31:0]     sram_addr,
    input  logic [31:0]     sram_wdata,
    output logic [31:0]     sram_rdata,
    input  logic [SW_W-1:0] switch_in,
    output logic [15:0]     led_out,
    output logic [31:0]     num_out,
    output logic            timer_irq
);
    localparam logic [15:0] OFF_LED   = 16'hF000;
    localparam logic [15:0] OFF_SW    = 16'hF004;
    localparam logic [15:0] OFF_NUM   = 16'hF008;
    localparam logic [15:0] OFF_TIMER = 16'hE000;
    localparam logic [15:0] OFF_CMP   = 16'hE004;

    // Replace the byte lanes selected by we, keep the others.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wd,
                                                input logic [3:0]  we);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (we[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0]       mem [0:(1<<RAM_AW)-1];
    logic [31:0]       timer;
    logic [SW_W-1:0]   sw_sync1;
    logic [SW_W-1:0]   sw_sync2;

    logic              is_mmio;
    logic [15:0]       off;
    logic [RAM_AW-1:0] ram_idx;
    logic              rd_req;
    logic              wr_req;
    logic              wr_ram;
    logic              wr_led;
    logic              wr_num;
    logic              wr_timer;
    logic [31:0]       rd_val;
    logic              unused_addr_lsb;

    // Address decode. RAM upper address bits simply alias.
    assign is_mmio         = (sram_addr[31:16] == MMIO_HI);
    assign off             = {sram_addr[15:2], 2'b00};
    assign ram_idx         = sram_addr[RAM_AW+1:2];
    assign unused_addr_lsb = ^sram_addr[1:0];

    assign rd_req   = sram_en & ~(|sram_we);
    assign wr_req   = sram_en & (|sram_we);
    assign wr_ram   = wr_req & ~is_mmio;
    assign wr_led   = wr_req & is_mmio & (off == OFF_LED);
    assign wr_num   = wr_req & is_mmio & (off == OFF_NUM);
    assign wr_timer = wr_req & is_mmio & (off == OFF_TIMER);

`ifdef TIMER_CMP_EN
    logic [31:0] cmp;
    logic        wr_cmp;

    assign wr_cmp = wr_req & is_mmio & (off == OFF_CMP);

    // Compare uses the pre-increment timer; a CMP write clears the flag and
    // takes priority over a match on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmp       <= 32'hFFFF_FFFF;
            timer_irq <= 1'b0;
        end else begin
            if (wr_cmp) cmp <= merge_bytes(cmp, sram_wdata, sram_we);
            if (wr_cmp)
                timer_irq <= 1'b0;
            else if (timer == cmp)
                timer_irq <= 1'b1;
        end
    end
`else
    assign timer_irq = 1'b0;
`endif

    // Read source select, sampled into sram_rdata at the request edge.
    always_comb begin
        rd_val = '0;
        if (!is_mmio) begin
            rd_val = mem[ram_idx];
        end else begin
            case (off)
                OFF_LED:   rd_val = {16'h0000, led_out};
                OFF_SW:    rd_val = 32'(sw_sync2);
                OFF_NUM:   rd_val = num_out;
                OFF_TIMER: rd_val = timer;
`ifdef TIMER_CMP_EN
                OFF_CMP:   rd_val = cmp;
`endif
                default:   rd_val = '0;
            endcase
        end
    end

    // RAM array: no reset, byte-lane write enables.
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (sram_we[i]) mem[ram_idx][8*i +: 8] <= sram_wdata[8*i +: 8];
            end
        end
    end

    // Registered read data and MMIO registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sram_rdata <= '0;
            led_out    <= 16'hFFFF;
            num_out    <= '0;
            timer      <= '0;
            sw_sync1   <= '0;
            sw_sync2   <= '0;
        end else begin
            sw_sync1 <= switch_in;
            sw_sync2 <= sw_sync1;
            if (rd_req) sram_rdata <= rd_val;
            if (wr_led && sram_we[0]) led_out[7:0]  <= sram_wdata[7:0];
            if (wr_led && sram_we[1]) led_out[15:8] <= sram_wdata[15:8];
            if (wr_num) num_out <= merge_bytes(num_out, sram_wdata, sram_we);
            // A timer write replaces the increment; unwritten bytes hold.
            if (wr_timer)
                timer <= merge_bytes(timer, sram_wdata, sram_we);
            else
                timer <= timer + 32'd1;
        end
    end

endmodule
